// File: rtl/layer1_pkg.sv
// Shared types and constants for the layer-1 sliding-window controller.
// Default geometry comes from LAYER1_WIDTH, overridable at build time.
`ifndef LAYER1_WIDTH
`define LAYER1_WIDTH 32
`endif

package layer1_pkg;

    localparam int KERNEL    = 3;
    localparam int LAYER1_W  = `LAYER1_WIDTH;
    localparam int LAYER1_CW = $clog2(LAYER1_W);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/layer1_pos_counter.sv
// Column/row position of the next pixel: column wraps at the row end, row saturates on the last row.
// Advances on adv, zeroes on clear; last flags the final pixel of the frame.
module layer1_pos_counter
    import layer1_pkg::*;
#(
    parameter int IMG_WIDTH  = LAYER1_W,
    parameter int IMG_HEIGHT = 32,
    parameter int CW         = $clog2(IMG_WIDTH),
    parameter int RW         = $clog2(IMG_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          adv,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last
);

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col_d, col_q;
    logic [RW-1:0] row_d, row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (adv) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                if (row_q != ROW_MAX) begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign last = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/layer1_window_ctrl.sv
// Sequencer for the layer-1 line buffers and 3x3 window register; flags valid windows to the MAC.
// Window valid one cycle after the completing pixel; a held window stalls pixel intake combinationally.
module layer1_window_ctrl
    import layer1_pkg::*;
#(
    parameter int IMG_WIDTH  = LAYER1_W,
    parameter int IMG_HEIGHT = 32,
    parameter int CW         = $clog2(IMG_WIDTH),
    parameter int RW         = $clog2(IMG_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic          shift_en,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          busy,
    output logic          done
);

    if (IMG_WIDTH < KERNEL || IMG_HEIGHT < KERNEL) begin : g_bad_geometry
        $error("layer1_window_ctrl: image smaller than the kernel");
    end

    ctrl_state_t   state_d, state_q;
    logic          win_valid_d, win_valid_q;
    logic [RW-1:0] win_row_d, win_row_q;
    logic [CW-1:0] win_col_d, win_col_q;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last_pix;
    logic          streaming;
    logic          accept;
    logic          new_win;
    logic          win_hs;
    logic          clear;

    assign streaming = (state_q == FILL) || (state_q == RUN);
    assign pix_ready = streaming && (!win_valid_q || win_ready);
    assign accept    = pix_valid && pix_ready;
    assign win_hs    = win_valid_q && win_ready;
    assign clear     = (state_q == IDLE) && start;
    // Wrap-region columns never complete a window, so stale data from the previous row is never flagged.
    assign new_win   = accept && (row >= RW'(KERNEL - 1)) && (col >= CW'(KERNEL - 1));

    layer1_pos_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .CW         (CW),
        .RW         (RW)
    ) u_pos (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .adv   (accept),
        .col   (col),
        .row   (row),
        .last  (last_pix)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FILL;
            FILL: begin
                if (accept && last_pix) state_d = DRAIN;
                else if (new_win)       state_d = RUN;
            end
            RUN:     if (accept && last_pix) state_d = DRAIN;
            DRAIN:   if (win_hs) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        win_valid_d = win_valid_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        if (new_win) begin
            win_valid_d = 1'b1;
            win_row_d   = row - RW'(KERNEL - 1);
            win_col_d   = col - CW'(KERNEL - 1);
        end else if (win_hs) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
        end
    end

    assign shift_en  = accept;
    assign win_valid = win_valid_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign busy      = (state_q == FILL) || (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_layer1_window_ctrl.sv
// Directed bench: a 5x4 instance for the handshake/stall/reset cases and a default 32x32 instance.
module tb_layer1_window_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 5x4 instance
    logic       s_start, s_pix_valid, s_pix_ready, s_shift_en;
    logic       s_win_valid, s_win_ready, s_busy, s_done;
    logic [1:0] s_win_row;
    logic [2:0] s_win_col;

    // 32x32 instance
    logic       l_start, l_pix_valid, l_pix_ready, l_shift_en;
    logic       l_win_valid, l_win_ready, l_busy, l_done;
    logic [4:0] l_win_row;
    logic [4:0] l_win_col;

    layer1_window_ctrl #(.IMG_WIDTH(5), .IMG_HEIGHT(4)) dut_s (
        .clk(clk), .rst(rst), .start(s_start),
        .pix_valid(s_pix_valid), .pix_ready(s_pix_ready), .shift_en(s_shift_en),
        .win_valid(s_win_valid), .win_ready(s_win_ready),
        .win_row(s_win_row), .win_col(s_win_col),
        .busy(s_busy), .done(s_done)
    );

    layer1_window_ctrl dut_l (
        .clk(clk), .rst(rst), .start(l_start),
        .pix_valid(l_pix_valid), .pix_ready(l_pix_ready), .shift_en(l_shift_en),
        .win_valid(l_win_valid), .win_ready(l_win_ready),
        .win_row(l_win_row), .win_col(l_win_col),
        .busy(l_busy), .done(l_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Hand-computed 5x4 window order: rows 2..3, cols 2..4 of the image.
    int exp_r [6] = '{0, 0, 0, 1, 1, 1};
    int exp_c [6] = '{0, 1, 2, 0, 1, 2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one 20-pixel frame on the 5x4 instance, scoring every window handshake.
    task automatic small_frame(input bit bubbles, input bit stall, input bit start_mid, input string tag);
        int  win_idx   = 0;
        int  shifts    = 0;
        int  cyc       = 0;
        int  done_cnt  = 0;
        int  stall_rem = 0;
        bit  stalled   = 0;
        bit  first     = 1;
        bit  fin       = 0;
        s_start = 1'b1; s_pix_valid = 1'b0; s_win_ready = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        while (!fin && cyc < 300) begin
            s_pix_valid = (shifts < 20) && (!bubbles || ($urandom_range(0, 1) == 1));
            if (stall && !stalled && s_win_valid && win_idx == 1) begin
                stall_rem = 5;
                stalled   = 1;
            end
            s_win_ready = (stall_rem == 0);
            s_start     = start_mid && (shifts == 15);
            @(negedge clk);
            if (cyc == 0) chk({tag, " busy_after_start"}, s_busy, 1);
            if (stall_rem > 0) begin
                chk({tag, " stall_valid"}, s_win_valid, 1);
                chk({tag, " stall_row"}, s_win_row, 0);
                chk({tag, " stall_col"}, s_win_col, 1);
                chk({tag, " stall_pix_ready"}, s_pix_ready, 0);
                chk({tag, " stall_shift_en"}, s_shift_en, 0);
                stall_rem--;
            end
            if (s_win_valid && s_win_ready) begin
                if (first) begin
                    chk({tag, " first_win_after_pixels"}, shifts, 13);
                    first = 0;
                end
                if (win_idx < 6) begin
                    chk({tag, " win_row"}, s_win_row, exp_r[win_idx]);
                    chk({tag, " win_col"}, s_win_col, exp_c[win_idx]);
                end
                win_idx++;
            end
            if (s_shift_en) shifts++;
            if (s_done) begin
                done_cnt++;
                chk({tag, " windows_before_done"}, win_idx, 6);
                fin = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_start = 1'b0; s_pix_valid = 1'b1; s_win_ready = 1'b1;
        chk({tag, " finished_in_budget"}, fin, 1);
        chk({tag, " window_count"}, win_idx, 6);
        chk({tag, " shift_count"}, shifts, 20);
        chk({tag, " done_pulses"}, done_cnt, 1);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, s_done, 0);
        chk({tag, " idle_after_done"}, s_busy, 0);
        chk({tag, " idle_pix_ready"}, s_pix_ready, 0);
        @(posedge clk); #1;
        s_pix_valid = 1'b0;
    endtask

    initial begin
        int er, ec, wins, shifts, cyc;
        bit fin;
        rst = 1'b1;
        s_start = 1'b0; s_pix_valid = 1'b0; s_win_ready = 1'b0;
        l_start = 1'b0; l_pix_valid = 1'b0; l_win_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        s_pix_valid = 1'b1; l_pix_valid = 1'b1;

        // Reset / idle: valid pixels without start are refused.
        repeat (3) begin
            @(negedge clk);
            chk("rst pix_ready", s_pix_ready, 0);
            chk("rst shift_en", s_shift_en, 0);
            chk("rst win_valid", s_win_valid, 0);
            chk("rst busy", s_busy, 0);
            chk("rst done", s_done, 0);
            chk("rst win_row", s_win_row, 0);
            chk("rst win_col", s_win_col, 0);
            chk("rst l_pix_ready", l_pix_ready, 0);
            chk("rst l_busy", l_busy, 0);
            @(posedge clk); #1;
        end
        s_pix_valid = 1'b0; l_pix_valid = 1'b0;

        small_frame(0, 0, 0, "full");
        small_frame(0, 1, 0, "backpressure");
        small_frame(1, 0, 0, "bubbles");
        small_frame(0, 0, 1, "start_in_run");

        // Reset after 9 accepted pixels.
        s_start = 1'b1; s_win_ready = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0; s_pix_valid = 1'b1;
        shifts = 0; cyc = 0;
        while (shifts < 9 && cyc < 50) begin
            @(negedge clk);
            if (s_shift_en) shifts++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("midrst pixels_fed", shifts, 9);
        s_pix_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst busy", s_busy, 0);
        chk("midrst win_valid", s_win_valid, 0);
        chk("midrst pix_ready", s_pix_ready, 0);
        chk("midrst done", s_done, 0);
        @(posedge clk); #1;
        small_frame(0, 0, 0, "after_rst");

        // Default 32x32 frame: 900 windows in raster order, last (29,29).
        l_start = 1'b1; l_win_ready = 1'b1;
        @(posedge clk); #1;
        l_start = 1'b0;
        er = 0; ec = 0; wins = 0; shifts = 0; cyc = 0; fin = 0;
        while (!fin && cyc < 1200) begin
            l_pix_valid = (shifts < 1024);
            @(negedge clk);
            if (l_win_valid && l_win_ready) begin
                chk("big win_row", l_win_row, er);
                chk("big win_col", l_win_col, ec);
                wins++;
                if (ec == 29) begin ec = 0; er++; end
                else ec++;
            end
            if (l_shift_en) shifts++;
            if (l_done) begin
                chk("big windows_before_done", wins, 900);
                fin = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        l_pix_valid = 1'b0;
        chk("big finished_in_budget", fin, 1);
        chk("big window_count", wins, 900);
        chk("big shift_count", shifts, 1024);
        chk("big last_win_row", l_win_row, 29);
        chk("big last_win_col", l_win_col, 29);
        @(negedge clk);
        chk("big idle_after_done", l_busy, 0);
        chk("big done_one_cycle", l_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/layer1_window_ctrl.md
Name: layer1_window_ctrl

Overview:
- Sequencer for the layer-1 sliding-window datapath: the line-buffer shift chains (width-2 deep per row) and the 3x3 window register.
- Accepts the row-major pixel stream with a valid/ready handshake and issues one shift enable per accepted pixel.
- Tracks row and column position, flags complete 3x3 windows (valid convolution, no padding) to the MAC stage with a valid/ready handshake, and reports frame completion.

Parameters:
- IMG_WIDTH, 32, pixels per row (equals `LAYER1_WIDTH`)
- IMG_HEIGHT, 32, rows per frame
- KERNEL, 3, window edge; windows exist for row >= KERNEL-1 and col >= KERNEL-1
- CW, $clog2(IMG_WIDTH), column counter width
- RW, $clog2(IMG_HEIGHT), row counter width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle frame start; ignored unless state == IDLE
- pix_valid  in  1  upstream pixel present
- pix_ready  out  1  controller accepts pixel this cycle
- shift_en  out  1  enable for line-buffer chains and window register; equals pix_valid && pix_ready
- win_valid  out  1  window register holds a complete window
- win_ready  in  1  MAC stage consumes the window
- win_row  out  RW  output-map row of the presented window (0..IMG_HEIGHT-KERNEL)
- win_col  out  CW  output-map column of the presented window (0..IMG_WIDTH-KERNEL)
- busy  out  1  high in FILL, RUN and DRAIN
- done  out  1  one-cycle pulse at frame end

Behaviour:
- States: IDLE, FILL, RUN, DRAIN, DONE.
  - IDLE: start -> FILL, clear counters.
  - FILL: streaming until the first window position (row KERNEL-1, col KERNEL-1) is accepted -> RUN.
  - RUN: accept -> advance counters; on accept of the last pixel (row H-1, col W-1) -> DRAIN.
  - DRAIN: wait for the final window handshake -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Reset: state=IDLE; col, row, win_row, win_col=0; win_valid, busy, done, pix_ready, shift_en=0.
- Accept: pix_ready = (state==FILL || state==RUN) && (!win_valid || win_ready). This is combinational from win_ready and allows back-to-back streaming at one pixel per cycle.
- Counters:
  - On accept, col increments; at col==IMG_WIDTH-1, col wraps to 0 and row increments.
  - row saturates at IMG_HEIGHT-1 until the next frame clears it.
- Window generation: accepting pixel (r,c) with r>=KERNEL-1 and c>=KERNEL-1 sets win_valid=1 on the next cycle, with win_row=r-(KERNEL-1) and win_col=c-(KERNEL-1). This gives a latency of 1 cycle, matching the registered line-buffer output.
- Window hold: win_valid and its coordinates stay stable until win_valid && win_ready.
  - Handshake with no new window in the same cycle: win_valid clears.
  - Handshake together with an accept that completes a new window: win_valid stays 1 and the coordinates update.
- Columns c < KERNEL-1 (row wrap region) never raise win_valid. Stale data crossing the row boundary therefore never reaches the MAC.
- Window count per frame: (IMG_WIDTH-KERNEL+1)*(IMG_HEIGHT-KERNEL+1).
- Stalls:
  - pix_valid low: nothing shifts; state and counters hold.
  - win_ready low while win_valid: pix_ready=0 and shift_en=0, so the chain freezes and no data is lost.
- start asserted while busy: ignored. start in the DONE cycle: ignored; a new start is required in IDLE.
- rst mid-frame: immediate return to IDLE with all outputs at reset values. Line-buffer contents are don't-care, because the next frame refills before any window is flagged.
- Degenerate case: IMG_WIDTH or IMG_HEIGHT < KERNEL is illegal; elaboration-time assertion.

Decomposition:
- Shared package layer1_pkg holds:
  - state enum ctrl_state_t {IDLE, FILL, RUN, DRAIN, DONE}
  - KERNEL constant
  - width localparams derived from `LAYER1_WIDTH`
- One natural sub-module: layer1_pos_counter, the col/row counter pair with wrap, saturation and last-pixel flag.
- The FSM and window-valid register stay in the top.

Test Plan:
- Reset/idle: rst for 2 cycles, pix_valid=1 without start -> pix_ready=0, shift_en=0, win_valid=0, busy=0, done=0.
- Full-speed frame (IMG_WIDTH=5, IMG_HEIGHT=4), start then 20 pixels with pix_valid=1 and win_ready=1 -> exactly 6 windows. The first window is the cycle after pixel 13 (r2,c2) with (0,0), then (0,1),(0,2),(1,0),(1,1),(1,2). done pulses once, then IDLE.
- Back-pressure: hold win_ready=0 for 5 cycles on window (0,1) -> win_valid, win_row=0, win_col=1 stable; pix_ready=0 and shift_en=0 throughout. Resume -> no pixel skipped and the window sequence is unchanged.
- Upstream bubbles: random pix_valid gaps (~50%) -> window coordinates and count are identical to the full-speed case. shift_en count equals 20.
- Start while busy / reset mid-frame: start pulse in RUN is ignored. rst after pixel 9 -> IDLE next cycle, win_valid=0. A fresh start plus 20 pixels yields 6 windows starting at (0,0).
- Default parameters (32x32): stream 1024 pixels -> 900 windows; the last window is (29,29); done asserts after the last handshake.
